// File: rtl/ram_rmw_arbiter.sv
// Front end for a single-port-pair RAM: masked writes become read-modify-write,
// the RAM read port is shared round-robin between reads and RMW reads, and a whole-RAM clear is sequenced.
module ram_rmw_arbiter #(
    parameter int DataWidth = 8,
    parameter int DataDepth = 1024,
    parameter int AddrWidth = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [AddrWidth-1:0] wr_addr,
    input  logic [DataWidth-1:0] wr_data,
    input  logic [DataWidth-1:0] wr_mask,
    input  logic                 rd_valid,
    output logic                 rd_ready,
    input  logic [AddrWidth-1:0] rd_addr,
    output logic                 rd_data_valid,
    output logic [DataWidth-1:0] rd_data,
    input  logic                 clear_start,
    input  logic [DataWidth-1:0] clear_value,
    output logic                 clear_done,
    output logic                 busy,
    output logic                 ram_write_en,
    output logic [AddrWidth-1:0] ram_write_addr,
    output logic [DataWidth-1:0] ram_write_data,
    output logic                 ram_read_en,
    output logic [AddrWidth-1:0] ram_read_addr,
    input  logic [DataWidth-1:0] ram_read_data
);

    typedef enum logic [1:0] {IDLE, MERGE, CLEAR} state_e;

    // rr_last records which requester last used the RAM read port.
    localparam logic RR_READ  = 1'b0;
    localparam logic RR_WRITE = 1'b1;

    state_e               state_q, state_d;
    logic                 rr_last_q, rr_last_d;
    logic                 rd_pend_q, rd_pend_d;
    logic                 fwd_q, fwd_d;
    logic                 clear_done_q, clear_done_d;
    logic [DataWidth-1:0] rd_hold_q, rd_hold_d;
    logic [DataWidth-1:0] fwd_data_q, fwd_data_d;
    logic [AddrWidth-1:0] m_addr_q, m_addr_d;
    logic [DataWidth-1:0] m_data_q, m_data_d;
    logic [DataWidth-1:0] m_mask_q, m_mask_d;
    logic [AddrWidth-1:0] ptr_q, ptr_d;
    logic [DataWidth-1:0] clear_val_q, clear_val_d;
    logic                 wr_masked, wr_fire, rd_fire;

    assign wr_masked     = (wr_mask != '0);
    assign busy          = (state_q != IDLE);
    assign clear_done    = clear_done_q;
    assign rd_data_valid = rd_pend_q;
    assign rd_data       = rd_pend_q ? (fwd_q ? fwd_data_q : ram_read_data) : rd_hold_q;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        state_d        = state_q;
        rr_last_d      = rr_last_q;
        rd_pend_d      = 1'b0;
        fwd_d          = 1'b0;
        clear_done_d   = 1'b0;
        rd_hold_d      = rd_data;
        fwd_data_d     = fwd_data_q;
        m_addr_d       = m_addr_q;
        m_data_d       = m_data_q;
        m_mask_d       = m_mask_q;
        ptr_d          = ptr_q;
        clear_val_d    = clear_val_q;
        wr_ready       = 1'b0;
        rd_ready       = 1'b0;
        wr_fire        = 1'b0;
        rd_fire        = 1'b0;
        ram_write_en   = 1'b0;
        ram_write_addr = '0;
        ram_write_data = '0;
        ram_read_en    = 1'b0;
        ram_read_addr  = '0;

        if (!reset) begin
            unique case (state_q)
                IDLE: begin
                    if (clear_start) begin
                        clear_val_d = clear_value;
                        ptr_d       = '0;
                        state_d     = CLEAR;
                    end else begin
                        // Only a masked write contends with a read, for the RAM read port.
                        wr_ready = !wr_masked || !rd_valid || (rr_last_q == RR_READ);
                        rd_ready = !(wr_valid && wr_masked && (rr_last_q == RR_READ));
                        wr_fire  = wr_valid && wr_ready;
                        rd_fire  = rd_valid && rd_ready;
                        if (wr_fire && !wr_masked) begin
                            ram_write_en   = 1'b1;
                            ram_write_addr = wr_addr;
                            ram_write_data = wr_data;
                        end
                        if (wr_fire && wr_masked) begin
                            ram_read_en   = 1'b1;
                            ram_read_addr = wr_addr;
                            m_addr_d      = wr_addr;
                            m_data_d      = wr_data;
                            m_mask_d      = wr_mask;
                            rr_last_d     = RR_WRITE;
                            state_d       = MERGE;
                        end else if (rd_fire) begin
                            ram_read_en   = 1'b1;
                            ram_read_addr = rd_addr;
                            rd_pend_d     = 1'b1;
                            rr_last_d     = RR_READ;
                            // The RAM returns old data on a same-address collision, so forward the new word.
                            fwd_d         = wr_fire && !wr_masked && (wr_addr == rd_addr);
                            fwd_data_d    = wr_data;
                        end
                    end
                end
                MERGE: begin
                    ram_write_en   = 1'b1;
                    ram_write_addr = m_addr_q;
                    ram_write_data = (ram_read_data & m_mask_q) | (m_data_q & ~m_mask_q);
                    state_d        = IDLE;
                end
                CLEAR: begin
                    ram_write_en   = 1'b1;
                    ram_write_addr = ptr_q;
                    ram_write_data = clear_val_q;
                    ptr_d          = ptr_q + AddrWidth'(1);
                    if (ptr_q == AddrWidth'(DataDepth - 1)) begin
                        clear_done_d = 1'b1;
                        state_d      = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            rr_last_q    <= RR_READ;
            rd_pend_q    <= 1'b0;
            fwd_q        <= 1'b0;
            clear_done_q <= 1'b0;
            rd_hold_q    <= '0;
        end else begin
            state_q      <= state_d;
            rr_last_q    <= rr_last_d;
            rd_pend_q    <= rd_pend_d;
            fwd_q        <= fwd_d;
            clear_done_q <= clear_done_d;
            rd_hold_q    <= rd_hold_d;
        end
    end

    // NOTE: datapath registers carry no reset; they are only consumed in states that first load them.
    always_ff @(posedge clk) begin
        fwd_data_q  <= fwd_data_d;
        m_addr_q    <= m_addr_d;
        m_data_q    <= m_data_d;
        m_mask_q    <= m_mask_d;
        ptr_q       <= ptr_d;
        clear_val_q <= clear_val_d;
    end

endmodule

// File: tb/tb_ram_rmw_arbiter.sv
// Self-checking bench for ram_rmw_arbiter with a behavioural RAM and a word-level memory reference.
module tb_ram_rmw_arbiter;

    localparam int DW = 8;
    localparam int DD = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_valid, wr_ready, rd_valid, rd_ready;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [DW-1:0] wr_data, wr_mask, rd_data, clear_value;
    logic          rd_data_valid, clear_start, clear_done, busy;
    logic          ram_write_en, ram_read_en;
    logic [AW-1:0] ram_write_addr, ram_read_addr;
    logic [DW-1:0] ram_write_data, ram_read_data;

    int checks = 0;
    int failures = 0;

    logic [DW-1:0] ram     [DD];
    logic [DW-1:0] ref_mem [DD];

    ram_rmw_arbiter #(.DataWidth(DW), .DataDepth(DD), .AddrWidth(AW)) dut (
        .clk(clk), .reset(reset),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
        .rd_data_valid(rd_data_valid), .rd_data(rd_data),
        .clear_start(clear_start), .clear_value(clear_value), .clear_done(clear_done), .busy(busy),
        .ram_write_en(ram_write_en), .ram_write_addr(ram_write_addr), .ram_write_data(ram_write_data),
        .ram_read_en(ram_read_en), .ram_read_addr(ram_read_addr), .ram_read_data(ram_read_data)
    );

    always #5 clk = ~clk;

    // Registered-read RAM: old data on a same-cycle read/write collision.
    always @(posedge clk) begin
        if (ram_write_en) ram[ram_write_addr] <= ram_write_data;
        if (ram_read_en)  ram_read_data <= ram[ram_read_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr_valid = 0; wr_addr = '0; wr_data = '0; wr_mask = '0;
        rd_valid = 0; rd_addr = '0; clear_start = 0; clear_value = '0;
    endtask

    function automatic logic [DW-1:0] merged(logic [DW-1:0] old, logic [DW-1:0] data, logic [DW-1:0] mask);
        return (old & mask) | (data & ~mask);
    endfunction

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        tick(); tick();
        reset = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1;
        wr_valid = 1; wr_addr = 4'd1; rd_valid = 1; rd_addr = 4'd2;
        tick(); tick();
        checks++; if (ram_write_en !== 1'b0 || ram_read_en !== 1'b0) begin failures++; $display("FAIL reset_ram_en got we=%b re=%b exp 0 0", ram_write_en, ram_read_en); end
        checks++; if ({rd_data_valid, clear_done, busy} !== 3'b000) begin failures++; $display("FAIL reset_flags got rdv/done/busy=%b exp 000", {rd_data_valid, clear_done, busy}); end
        checks++; if (rd_data !== '0) begin failures++; $display("FAIL reset_rd_data got=%h exp=00", rd_data); end
        idle_inputs();
        reset = 0;
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_idle_busy got=%b exp=0", busy); end
    endtask

    task automatic test_clear(input logic [DW-1:0] value);
        int  done_at = -1;
        logic stall_bad = 0;
        clear_start = 1; clear_value = value;
        wr_valid = 1; wr_mask = '0; wr_addr = 4'd6; wr_data = 8'h3E;
        rd_valid = 1; rd_addr = 4'd6;
        #1;
        checks++; if ({wr_ready, rd_ready, ram_write_en} !== 3'b000) begin failures++; $display("FAIL clear_start_priority got wr_rdy/rd_rdy/we=%b exp 000", {wr_ready, rd_ready, ram_write_en}); end
        tick();
        clear_start = 0; clear_value = ~value;
        for (int n = 1; n <= 40 && done_at < 0; n++) begin
            if (n == 3) clear_start = 1;
            if (n == 5) clear_start = 0;
            #1;
            if (wr_ready || rd_ready || !busy) stall_bad = 1;
            tick();
            if (clear_done) done_at = n;
        end
        idle_inputs();
        checks++; if (stall_bad !== 1'b0) begin failures++; $display("FAIL clear_stall got ready/busy violation=%b exp=0", stall_bad); end
        checks++; if (done_at != DD) begin failures++; $display("FAIL clear_done_cycle got=%0d exp=%0d", done_at, DD); end
        tick();
        checks++; if ({clear_done, busy} !== 2'b00) begin failures++; $display("FAIL clear_done_pulse got done/busy=%b exp 00", {clear_done, busy}); end
        for (int a = 0; a < DD; a++) ref_mem[a] = value;
        for (int a = 0; a < DD; a++) begin
            rd_valid = 1; rd_addr = AW'(a);
            tick();
            checks++; if (rd_data_valid !== 1'b1 || rd_data !== ref_mem[a]) begin failures++; $display("FAIL clear_readback addr=%0d got v=%b d=%h exp v=1 d=%h", a, rd_data_valid, rd_data, ref_mem[a]); end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_direct_write_read();
        wr_valid = 1; wr_addr = 4'd3; wr_data = 8'h5A; wr_mask = '0;
        #1;
        checks++; if (wr_ready !== 1'b1 || ram_write_en !== 1'b1) begin failures++; $display("FAIL direct_wr_accept got rdy=%b we=%b exp 1 1", wr_ready, ram_write_en); end
        tick();
        ref_mem[3] = 8'h5A;
        idle_inputs();
        checks++; if (rd_data_valid !== 1'b0) begin failures++; $display("FAIL direct_no_spurious_rdv got=%b exp=0", rd_data_valid); end
        rd_valid = 1; rd_addr = 4'd3;
        tick();
        rd_valid = 0;
        checks++; if (rd_data_valid !== 1'b1 || rd_data !== ref_mem[3]) begin failures++; $display("FAIL direct_read got v=%b d=%h exp v=1 d=%h", rd_data_valid, rd_data, ref_mem[3]); end
        tick();
        checks++; if (rd_data_valid !== 1'b0 || rd_data !== ref_mem[3]) begin failures++; $display("FAIL read_hold got v=%b d=%h exp v=0 d=%h", rd_data_valid, rd_data, ref_mem[3]); end
    endtask

    task automatic test_masked_write();
        logic [DW-1:0] exp;
        wr_valid = 1; wr_addr = 4'd7; wr_data = 8'hF0; wr_mask = '0;
        tick();
        ref_mem[7] = 8'hF0;
        wr_data = 8'h0F; wr_mask = 8'hF0;
        #1;
        checks++; if (wr_ready !== 1'b1 || ram_read_en !== 1'b1 || ram_write_en !== 1'b0) begin failures++; $display("FAIL masked_accept got rdy=%b re=%b we=%b exp 1 1 0", wr_ready, ram_read_en, ram_write_en); end
        tick();
        exp = merged(ref_mem[7], 8'h0F, 8'hF0);
        ref_mem[7] = exp;
        #1;
        checks++; if (wr_ready !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL merge_stall got rdy=%b busy=%b exp 0 1", wr_ready, busy); end
        checks++; if (ram_write_en !== 1'b1 || ram_write_addr !== 4'd7 || ram_write_data !== exp) begin failures++; $display("FAIL merge_write got we=%b a=%h d=%h exp 1 7 %h", ram_write_en, ram_write_addr, ram_write_data, exp); end
        wr_valid = 0; rd_valid = 1; rd_addr = 4'd7;
        #1;
        checks++; if (rd_ready !== 1'b0) begin failures++; $display("FAIL merge_rd_stall got=%b exp=0", rd_ready); end
        tick();
        checks++; if (rd_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL merge_return got rdy=%b busy=%b exp 1 0", rd_ready, busy); end
        tick();
        idle_inputs();
        checks++; if (rd_data_valid !== 1'b1 || rd_data !== ref_mem[7]) begin failures++; $display("FAIL masked_read got v=%b d=%h exp v=1 d=%h", rd_data_valid, rd_data, ref_mem[7]); end
        tick();
    endtask

    task automatic test_forwarding();
        wr_valid = 1; wr_addr = 4'd9; wr_data = 8'h11; wr_mask = '0;
        tick();
        ref_mem[9] = 8'h11;
        wr_data = 8'h33; rd_valid = 1; rd_addr = 4'd9;
        #1;
        checks++; if (wr_ready !== 1'b1 || rd_ready !== 1'b1) begin failures++; $display("FAIL fwd_dual_grant got wr=%b rd=%b exp 1 1", wr_ready, rd_ready); end
        tick();
        ref_mem[9] = 8'h33;
        wr_addr = 4'd10; wr_data = 8'h44;
        checks++; if (rd_data_valid !== 1'b1 || rd_data !== ref_mem[9]) begin failures++; $display("FAIL fwd_same_addr got v=%b d=%h exp v=1 d=%h", rd_data_valid, rd_data, ref_mem[9]); end
        tick();
        ref_mem[10] = 8'h44;
        idle_inputs();
        checks++; if (rd_data !== ref_mem[9]) begin failures++; $display("FAIL fwd_other_addr got=%h exp=%h", rd_data, ref_mem[9]); end
        tick();
    endtask

    task automatic test_round_robin();
        logic [DW-1:0] wdat [4] = '{8'hA5, 8'h5A, 8'hC3, 8'h96};
        logic          gseq [4];
        logic [DW-1:0] exp;
        logic          wg, rg;
        int            g = 0;
        int            wi = 0;
        wr_valid = 1; wr_addr = 4'd1; wr_data = 8'h3C; wr_mask = '0;
        tick();
        ref_mem[1] = 8'h3C;
        do_reset();
        for (int c = 0; c < 20 && g < 4; c++) begin
            wr_valid = 1; wr_addr = 4'd1; wr_mask = 8'h0F; wr_data = wdat[wi];
            rd_valid = 1; rd_addr = 4'd1;
            #1;
            wg = wr_ready; rg = rd_ready;
            if (wg) begin
                if (g < 4) gseq[g] = 1'b1;
                g++;
                ref_mem[1] = merged(ref_mem[1], wdat[wi], 8'h0F);
                if (wi < 3) wi++;
            end
            if (rg) begin
                if (g < 4) gseq[g] = 1'b0;
                g++;
                exp = ref_mem[1];
            end
            tick();
            if (rg) begin
                checks++; if (rd_data_valid !== 1'b1 || rd_data !== exp) begin failures++; $display("FAIL rr_read_data got v=%b d=%h exp v=1 d=%h", rd_data_valid, rd_data, exp); end
            end
        end
        idle_inputs();
        checks++; if (g != 4) begin failures++; $display("FAIL rr_grant_count got=%0d exp=4", g); end
        for (int i = 0; i < 4 && i < g; i++) begin
            checks++; if (gseq[i] !== ((i % 2) == 0)) begin failures++; $display("FAIL rr_order idx=%0d got write=%b exp write=%b", i, gseq[i], (i % 2) == 0); end
        end
        tick(); tick();
    endtask

    task automatic test_reset_abort();
        int done_seen = 0;
        wr_valid = 1; wr_addr = 4'd5; wr_data = 8'h12; wr_mask = '0;
        tick();
        ref_mem[5] = 8'h12;
        wr_data = 8'hF0; wr_mask = 8'h0F;
        tick();
        wr_valid = 0; reset = 1;
        #1;
        checks++; if (ram_write_en !== 1'b0) begin failures++; $display("FAIL merge_reset_we got=%b exp=0", ram_write_en); end
        tick();
        reset = 0;
        checks++; if (busy !== 1'b0 || rd_data_valid !== 1'b0) begin failures++; $display("FAIL merge_reset_idle got busy=%b rdv=%b exp 0 0", busy, rd_data_valid); end
        rd_valid = 1; rd_addr = 4'd5;
        tick();
        rd_valid = 0;
        checks++; if (rd_data !== ref_mem[5]) begin failures++; $display("FAIL merge_dropped got=%h exp=%h", rd_data, ref_mem[5]); end
        clear_start = 1; clear_value = 8'h99;
        tick();
        clear_start = 0;
        repeat (5) tick();
        reset = 1;
        #1;
        checks++; if (ram_write_en !== 1'b0) begin failures++; $display("FAIL clear_reset_we got=%b exp=0", ram_write_en); end
        tick();
        reset = 0;
        for (int a = 0; a < 5; a++) ref_mem[a] = 8'h99;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (clear_done || busy) done_seen++;
        end
        checks++; if (done_seen != 0) begin failures++; $display("FAIL clear_abort got done/busy cycles=%0d exp=0", done_seen); end
        for (int a = 0; a < DD; a++) begin
            rd_valid = 1; rd_addr = AW'(a);
            tick();
            checks++; if (rd_data_valid !== 1'b1 || rd_data !== ref_mem[a]) begin failures++; $display("FAIL abort_readback addr=%0d got v=%b d=%h exp v=1 d=%h", a, rd_data_valid, rd_data, ref_mem[a]); end
        end
        idle_inputs();
        tick();
    endtask

    // Reference: a masked write blocks the arbiter for the following cycle; reads and masked
    // writes alternate on contest, starting with the write after reset.
    task automatic test_random();
        int            merge_left = 0;
        logic          write_next = 1;
        logic          pend = 0;
        logic [DW-1:0] exp_rd = '0;
        logic          ewg, erg, masked;
        do_reset();
        exp_rd = '0;
        for (int c = 0; c < 400; c++) begin
            wr_valid = ($urandom_range(0, 9) < 6);
            wr_addr  = AW'($urandom_range(0, 7));
            wr_data  = DW'($urandom);
            wr_mask  = ($urandom_range(0, 1) == 0) ? '0 : DW'($urandom_range(1, 255));
            rd_valid = ($urandom_range(0, 9) < 6);
            rd_addr  = AW'($urandom_range(0, 7));
            masked   = (wr_mask != '0);
            if (merge_left > 0) begin
                ewg = 0; erg = 0;
                merge_left = 0;
            end else if (wr_valid && masked && rd_valid) begin
                ewg = write_next; erg = !write_next;
            end else begin
                ewg = wr_valid; erg = rd_valid;
            end
            #1;
            checks++; if ({wr_valid && wr_ready, rd_valid && rd_ready} !== {ewg, erg}) begin failures++; $display("FAIL rand_grant cyc=%0d got wr/rd=%b%b exp %b%b", c, wr_valid && wr_ready, rd_valid && rd_ready, ewg, erg); end
            if (ewg) begin
                if (masked) begin
                    ref_mem[wr_addr] = merged(ref_mem[wr_addr], wr_data, wr_mask);
                    merge_left = 1;
                    write_next = 0;
                end else begin
                    ref_mem[wr_addr] = wr_data;
                end
            end
            if (erg) begin
                exp_rd = ref_mem[rd_addr];
                write_next = 1;
            end
            pend = erg;
            tick();
            checks++; if (rd_data_valid !== pend || rd_data !== exp_rd) begin failures++; $display("FAIL rand_read cyc=%0d got v=%b d=%h exp v=%b d=%h", c, rd_data_valid, rd_data, pend, exp_rd); end
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        reset = 1;
        test_reset();
        test_clear(8'hAA);
        test_direct_write_read();
        test_masked_write();
        test_forwarding();
        test_round_robin();
        test_reset_abort();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
